gpr_wb_arb: RTL

- Write-side producer for the 3-read/1-write GPR file.
- Merges results from the execute pipe (EX) and the load/store unit (LS) into the single GPR write port (wr_en_0/wr_adr_0/wr_dat_0).
- LS results are buffered in a small FIFO. EX has fixed priority.
- A starvation counter forces LS drain by back-pressuring EX.

---
 rtl/gpr_wb_arb_if.sv | 24 ++
 rtl/gpr_wb_arb.sv | 75 +++++++
 2 files changed

// File: rtl/gpr_wb_arb_if.sv
// gpr_wb_arb_if: EX/LS result inputs and GPR write port of gpr_wb_arb.
// GPR_WB_BYPASS_EN adds the read-address / bypass signals.
interface gpr_wb_arb_if #(parameter int DEPTH = 4);
  logic ex_valid, ex_ready, ls_valid, ls_ready, wr_en_0;
  logic [4:0] ex_adr, ls_adr, wr_adr_0;
  logic [31:0] ex_dat, ls_dat, wr_dat_0;
  logic [$clog2(DEPTH):0] ls_cnt;
`ifdef GPR_WB_BYPASS_EN
  logic [4:0] rd_adr_0, rd_adr_1, rd_adr_2;
  logic byp_hit_0, byp_hit_1, byp_hit_2;
  logic [31:0] byp_dat_0, byp_dat_1, byp_dat_2;
  modport slave(input ex_valid, ex_adr, ex_dat, ls_valid, ls_adr, ls_dat, rd_adr_0, rd_adr_1, rd_adr_2,
                output ex_ready, ls_ready, wr_en_0, wr_adr_0, wr_dat_0, ls_cnt,
                byp_hit_0, byp_hit_1, byp_hit_2, byp_dat_0, byp_dat_1, byp_dat_2);
  modport master(output ex_valid, ex_adr, ex_dat, ls_valid, ls_adr, ls_dat, rd_adr_0, rd_adr_1, rd_adr_2,
                 input ex_ready, ls_ready, wr_en_0, wr_adr_0, wr_dat_0, ls_cnt,
                 byp_hit_0, byp_hit_1, byp_hit_2, byp_dat_0, byp_dat_1, byp_dat_2);
`else
  modport slave(input ex_valid, ex_adr, ex_dat, ls_valid, ls_adr, ls_dat,
                output ex_ready, ls_ready, wr_en_0, wr_adr_0, wr_dat_0, ls_cnt);
  modport master(output ex_valid, ex_adr, ex_dat, ls_valid, ls_adr, ls_dat,
                 input ex_ready, ls_ready, wr_en_0, wr_adr_0, wr_dat_0, ls_cnt);
`endif
endinterface

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb: merges EX (fixed priority) and FIFO-buffered LS results onto the GPR write port.
// Optional macro GPR_WB_BYPASS_EN adds same-cycle write-to-read bypass outputs.
module gpr_wb_arb #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic reset,
  gpr_wb_arb_if.slave b
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [4:0] adr_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic wen_q;
  logic [4:0] wadr_q, wadr_d;
  logic [31:0] wdat_q, wdat_d;
  logic empty, push, pop, ex_go;
  always_comb begin
    empty  = cnt_q == '0;
    push   = b.ls_valid & b.ls_ready;
    ex_go  = b.ex_valid & b.ex_ready;
    pop    = ~ex_go & ~empty;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    // with a head present, not popping means EX won this cycle
    wcnt_d = (empty | pop) ? '0 : wcnt_q + 1'b1;
    wadr_d = ex_go ? b.ex_adr : pop ? adr_q[rp_q] : wadr_q;
    wdat_d = ex_go ? b.ex_dat : pop ? dat_q[rp_q] : wdat_q;
  end
  assign b.ls_ready = cnt_q != CW'(DEPTH);
  assign b.ex_ready = wcnt_q != WW'(MAX_WAIT);
  assign b.wr_en_0  = wen_q;
  assign b.wr_adr_0 = wadr_q;
  assign b.wr_dat_0 = wdat_q;
  assign b.ls_cnt   = cnt_q;
  always_ff @(posedge clk)
    if (push) begin
      adr_q[wp_q] <= b.ls_adr;
      dat_q[wp_q] <= b.ls_dat;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
      wen_q  <= 1'b0;
      wadr_q <= '0;
      wdat_q <= '0;
    end else begin
      wp_q   <= wp_q + AW'(push);
      rp_q   <= rp_q + AW'(pop);
      cnt_q  <= cnt_d;
      wcnt_q <= wcnt_d;
      wen_q  <= ex_go | pop;
      wadr_q <= wadr_d;
      wdat_q <= wdat_d;
    end
`ifdef GPR_WB_BYPASS_EN
  logic [2:0] hit;
  assign hit[0] = wen_q & (b.rd_adr_0 == wadr_q);
  assign hit[1] = wen_q & (b.rd_adr_1 == wadr_q);
  assign hit[2] = wen_q & (b.rd_adr_2 == wadr_q);
  assign b.byp_hit_0 = hit[0];
  assign b.byp_hit_1 = hit[1];
  assign b.byp_hit_2 = hit[2];
  assign b.byp_dat_0 = hit[0] ? wdat_q : '0;
  assign b.byp_dat_1 = hit[1] ? wdat_q : '0;
  assign b.byp_dat_2 = hit[2] ? wdat_q : '0;
`endif
endmodule
